// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, op codes, FSM states.
package mdu_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);

    // Codes 6 and 7 are not listed; they are accepted and do nothing.
    typedef enum logic [2:0] {
        MDU_MULTU = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_DIVU  = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage (master) and the MDU (slave).
interface mult_div_unit_if;
    import mdu_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mdu_sign_fixup.sv
// Sign handling shared by multiply and divide: magnitudes on entry, result negation in FIX.
module mdu_sign_fixup
    import mdu_pkg::*;
(
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               sign_a,
    output logic               sign_b,
    input  logic               is_div,
    input  logic               neg_res,
    input  logic               neg_rem,
    input  logic [2*WIDTH-1:0] acc,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Operand magnitudes for the unsigned datapath.
    always_comb begin
        sign_a = is_signed & a[WIDTH-1];
        sign_b = is_signed & b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // Restore signs: whole product, or quotient (sign a^b) and remainder (sign a) separately.
    always_comb begin
        product = neg_res ? -acc : acc;
        quot    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi  = is_div ? rem  : product[2*WIDTH-1:WIDTH];
        res_lo  = is_div ? quot : product[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with private HI/LO; 33 busy cycles per mul/div.
module mult_div_unit
    import mdu_pkg::*;
(
    input logic              clock,
    input logic              reset_n,
    mult_div_unit_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS - 1);

    mdu_state_e         state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   divisor;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;

    logic               req_signed;
    logic               req_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_acc;

    assign req_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    assign req_div    = (bus.op == MDU_DIVU) || (bus.op == MDU_DIV);

    mdu_sign_fixup u_sign_fixup (
        .is_signed (req_signed),
        .a         (bus.operand_a),
        .b         (bus.operand_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .is_div    (is_div),
        .neg_res   (neg_res),
        .neg_rem   (neg_rem),
        .acc       (acc),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    // One iteration: shift-add multiply (multiplier in low half) or restoring divide.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
        if (!is_div) begin
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
            step_acc = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Control FSM with datapath state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            divisor  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV: begin
                                acc      <= {{WIDTH{1'b0}}, mag_a};
                                divisor  <= mag_b;
                                is_div   <= req_div;
                                neg_res  <= sign_a ^ sign_b;
                                neg_rem  <= sign_a;
                                div_zero <= req_div && (bus.operand_b == '0);
                                count    <= '0;
                                busy_r   <= 1'b1;
                                state    <= RUN;
                            end
                            MDU_MTHI: hi_r <= bus.operand_a;
                            MDU_MTLO: lo_r <= bus.operand_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc   <= step_acc;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                    if (!bus.flush) begin
                        hi_r   <= res_hi;
                        // Zero divisor: quotient is all ones whatever the signs.
                        lo_r   <= div_zero ? '1 : res_lo;
                        dbz_r  <= div_zero;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the execute stage, directly downstream of the register file. It consumes the two register read operands (rs on operand_a, rt on operand_b) and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into private HI/LO registers. HI/LO are read by MFHI/MFLO through the hi/lo outputs. The pipeline stalls on busy.

## Interface
- WIDTH, 32, operand and HI/LO width; fixed at 32 for this core.
- clock  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge, accepted only when busy=0.
- op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO; 6/7 accepted as no-op.
- operand_a  input  32  rs value (multiplicand / dividend / MTHI-MTLO source).
- operand_b  input  32  rt value (multiplier / divisor).
- flush  input  1  synchronous cancel of an in-flight operation.
- busy  output  1  high while an iterative operation is in flight.
- done  output  1  one-cycle pulse in the cycle after HI/LO take a multiply/divide result.
- div_by_zero  output  1  registered; set with done when a divide had operand_b=0, else cleared on done.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1, op 0-3: latch |a|, |b| (signed ops) or raw a, b (unsigned ops), result signs, op; clear 5-bit count; go to RUN.
- IDLE with start=1, op 4/5: write hi (4) or lo (5) with operand_a on that edge; stay IDLE; no busy, no done.
- RUN: one radix-2 step per cycle (shift-add multiply, restoring divide) on 64-bit accumulator; count increments; after the step with count=31, go to FIX.
- FIX: apply sign correction, write hi/lo, go to IDLE; done=1 for the following cycle.
- Multiply result: {hi, lo} = 64-bit product, two's-complement for MULT.
- Divide result: lo = quotient, hi = remainder; signed quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
- Divide by zero (any sign): lo = 32'hFFFFFFFF, hi = operand_a, full latency, div_by_zero=1.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0, no exception.
- start while busy=1: ignored; no queuing.
- flush: when high on an edge in RUN or FIX, return to IDLE; hi/lo unchanged; no done. flush with start in IDLE: start ignored.
- reset_n low (any state, mid-operation included): immediately IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, count=0.

## Timing
- Start accepted on edge E0; busy=1 from after E0 through the FIX cycle (33 cycles).
- HI/LO updated on edge E0+33; busy=0 and done=1 in the cycle after E0+33.
- Back-to-back: a new start may be sampled on the edge where done is high. Throughput is 34 cycles per op.
- MTHI/MTLO: zero added latency; the value is visible on hi/lo in the cycle after the edge.
- While busy=1, hi/lo hold the old values; the pipeline must stall MFHI/MFLO on busy.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.

## Structure
- mdu_pkg: op encodings (MDU_MULTU..MDU_MTLO), state enum {IDLE, RUN, FIX}, WIDTH=32, ITERATIONS=32.
- Sub-module mdu_sign_fixup: combinational absolute-value on entry and negation of product, quotient and remainder in FIX. It is shared by multiply and divide.
- The FSM, counter and accumulator live in mult_div_unit.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done 34 cycles after start, busy high 33 cycles.
- MULT -3 × 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU 100 / 0 -> lo=32'hFFFFFFFF, hi=100, div_by_zero=1; a following DIVU 100 / 7 -> lo=14, hi=2, div_by_zero=0.
- DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0; MTHI 32'h1234 then MTLO 32'h5678 on consecutive cycles -> hi=32'h1234, lo=32'h5678, busy never set.
- Start MULT, assert flush at cycle 10 -> IDLE, hi/lo keep previous values, no done; a second start during busy is ignored (result matches the first op only).
- Assert reset_n low asynchronously mid-RUN -> hi=lo=0, busy=0 immediately. Deassert, then MULTU 6×7 -> lo=42, hi=0.
